// File: rtl/vector_mem_pkg.sv
// rtl/vector_mem_pkg.sv - shared defaults, state encoding and opcodes for the vector memory responder
package vector_mem_pkg;

    // Default vector geometry: one memory word is one full register vector.
    localparam int LANES  = 32;
    localparam int LANE_W = 16;
    localparam int WORD_W = LANES * LANE_W;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_e;

    // Memory opcodes used by the processing block when issuing requests.
    localparam logic [7:0] OP_LOAD  = 8'b0010_0000;
    localparam logic [7:0] OP_STORE = 8'b0001_0000;

endpackage

// File: rtl/mem_delay_line.sv
// rtl/mem_delay_line.sv - LATENCY-deep valid+data shift register carrying load responses
//
// Ports:
//   clock     rising-edge clock
//   reset     synchronous active-high flush of every stage
//   in_valid  response present at the array read stage
//   in_data   response word from the array read stage
//   out_valid one-cycle strobe, LATENCY edges after in_valid was captured
//   out_data  response word; holds its last value while out_valid is low
module mem_delay_line #(
    parameter int DATA_W  = 512,
    parameter int LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic              valid_q [LATENCY];
    logic              valid_d [LATENCY];
    logic [DATA_W-1:0] data_q  [LATENCY];
    logic [DATA_W-1:0] data_d  [LATENCY];

    // A stage's data only moves when the stage behind it is valid, so the
    // last stage keeps the most recent response between strobes.
    always_comb begin
        valid_d[0] = in_valid;
        data_d[0]  = in_valid ? in_data : data_q[0];
        for (int i = 1; i < LATENCY; i++) begin
            valid_d[i] = valid_q[i-1];
            data_d[i]  = valid_q[i-1] ? data_q[i-1] : data_q[i];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                valid_q[i] <= 1'b0;
                data_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < LATENCY; i++) begin
                valid_q[i] <= valid_d[i];
                data_q[i]  <= data_d[i];
            end
        end
    end

    assign out_valid = valid_q[LATENCY-1];
    assign out_data  = data_q[LATENCY-1];

endmodule

// File: rtl/vector_mem_responder.sv
// rtl/vector_mem_responder.sv - vector-word memory responder with reset-time clear sequencer
//
// Ports:
//   clock, reset            single clock, synchronous active-high reset
//   load_ctrl, load_addr    load request and word address
//   load_data, load_valid   response word and its one-cycle strobe
//   write_ctrl, write_addr,
//   write_data              store request, word address and vector word
//   ready                   high once the clear sequence has finished
//   err                     sticky error (dropped or out-of-range request)
//
// READ_LATENCY must be within 1..4 and DEPTH must not exceed 2**ADDR_W.
module vector_mem_responder #(
    parameter int LANES        = vector_mem_pkg::LANES,
    parameter int LANE_W       = vector_mem_pkg::LANE_W,
    parameter int ADDR_W       = 16,
    parameter int DEPTH        = 1024,
    parameter int READ_LATENCY = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      load_ctrl,
    input  logic [ADDR_W-1:0]         load_addr,
    output logic [LANES*LANE_W-1:0]   load_data,
    output logic                      load_valid,
    input  logic                      write_ctrl,
    input  logic [ADDR_W-1:0]         write_addr,
    input  logic [LANES*LANE_W-1:0]   write_data,
    output logic                      ready,
    output logic                      err
);

    import vector_mem_pkg::*;

    localparam int W     = LANES * LANE_W;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [IDX_W-1:0]  LAST_PTR  = IDX_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  clear_ptr_q, clear_ptr_d;
    logic              err_q, err_d;

    // No reset on the array itself: the CLEAR sequence zeroes it.
    logic [W-1:0]      mem_q [DEPTH];

    logic              mem_we;
    logic [IDX_W-1:0]  mem_waddr;
    logic [W-1:0]      mem_wdata;

    logic              rd_valid;
    logic [W-1:0]      rd_data;

    logic              load_in_range;
    logic              write_in_range;
    logic              write_hits_load;

    // Compare with one extra bit so DEPTH == 2**ADDR_W cannot wrap, and
    // compare the full address so upper bits never alias.
    assign load_in_range   = ({1'b0, load_addr}  < DEPTH_EXT);
    assign write_in_range  = ({1'b0, write_addr} < DEPTH_EXT);
    assign write_hits_load = write_ctrl && write_in_range && (write_addr == load_addr);

    always_comb begin
        state_d     = state_q;
        clear_ptr_d = clear_ptr_q;
        err_d       = err_q;
        mem_we      = 1'b0;
        mem_waddr   = '0;
        mem_wdata   = '0;
        rd_valid    = 1'b0;
        rd_data     = '0;

        case (state_q)
            CLEAR: begin
                mem_we      = 1'b1;
                mem_waddr   = clear_ptr_q;
                clear_ptr_d = clear_ptr_q + 1'b1;
                if (clear_ptr_q == LAST_PTR) begin
                    state_d     = IDLE;
                    clear_ptr_d = '0;
                end
                // Requests before ready are dropped.
                if (load_ctrl || write_ctrl) begin
                    err_d = 1'b1;
                end
            end

            IDLE: begin
                if (write_ctrl) begin
                    if (write_in_range) begin
                        mem_we    = 1'b1;
                        mem_waddr = write_addr[IDX_W-1:0];
                        mem_wdata = write_data;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (load_ctrl) begin
                    // Out-of-range loads still answer on schedule, with zero.
                    rd_valid = 1'b1;
                    if (load_in_range) begin
                        rd_data = write_hits_load ? write_data
                                                  : mem_q[load_addr[IDX_W-1:0]];
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d     = CLEAR;
                clear_ptr_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= CLEAR;
            clear_ptr_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            clear_ptr_q <= clear_ptr_d;
            err_q       <= err_d;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we && !reset) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    mem_delay_line #(
        .DATA_W  (W),
        .LATENCY (READ_LATENCY)
    ) u_delay (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (rd_valid),
        .in_data   (rd_data),
        .out_valid (load_valid),
        .out_data  (load_data)
    );

    assign ready = (state_q == IDLE);
    assign err   = err_q;

endmodule

// File: tb/tb_vector_mem_responder.sv
// tb/tb_vector_mem_responder.sv - directed scoreboard bench over READ_LATENCY 1, 2 and 3
module tb_vector_mem_responder;

    localparam int NI    = 3;
    localparam int DEPTH = 16;
    localparam int AW    = 16;
    localparam int WW    = 512;

    logic          clock      = 1'b0;
    logic          reset      = 1'b1;
    logic          load_ctrl  = 1'b0;
    logic          write_ctrl = 1'b0;
    logic [AW-1:0] load_addr  = '0;
    logic [AW-1:0] write_addr = '0;
    logic [WW-1:0] write_data = '0;

    logic          lv  [NI];
    logic [WW-1:0] ld  [NI];
    logic          rdy [NI];
    logic          er  [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        vector_mem_responder #(
            .LANES        (32),
            .LANE_W       (16),
            .ADDR_W       (AW),
            .DEPTH        (DEPTH),
            .READ_LATENCY (g + 1)
        ) u_dut (
            .clock      (clock),
            .reset      (reset),
            .load_ctrl  (load_ctrl),
            .load_addr  (load_addr),
            .load_data  (ld[g]),
            .load_valid (lv[g]),
            .write_ctrl (write_ctrl),
            .write_addr (write_addr),
            .write_data (write_data),
            .ready      (rdy[g]),
            .err        (er[g])
        );
    end

    always #5 clock = ~clock;

    typedef struct {
        int            due;
        logic [WW-1:0] data;
    } exp_t;

    exp_t          sq [NI][$];
    logic [WW-1:0] last_exp [NI];
    logic [WW-1:0] mem_m [DEPTH];
    logic          err_exp  = 1'b0;
    logic          idle_exp = 1'b0;
    int            cyc   = 0;
    int            tests = 0;
    int            fails = 0;

    always @(posedge clock) cyc++;

    task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WW-1:0] rep(input logic [15:0] v);
        return {32{v}};
    endfunction

    // Response monitor: each expected entry must appear exactly at its due cycle.
    always @(posedge clock) begin
        #1;
        for (int i = 0; i < NI; i++) begin
            if (sq[i].size() > 0 && sq[i][0].due == cyc) begin
                chk($sformatf("valid_rl%0d", i + 1), WW'(lv[i]), WW'(1));
                chk($sformatf("data_rl%0d", i + 1), ld[i], sq[i][0].data);
                last_exp[i] = sq[i][0].data;
                void'(sq[i].pop_front());
            end else begin
                chk($sformatf("no_valid_rl%0d", i + 1), WW'(lv[i]), WW'(0));
                chk($sformatf("hold_rl%0d", i + 1), ld[i], last_exp[i]);
            end
        end
    end

    // One request cycle; called at a negedge, returns at the next negedge.
    task automatic step(input logic l_en, input logic [AW-1:0] la,
                        input logic w_en, input logic [AW-1:0] wa,
                        input logic [WW-1:0] wd);
        logic          w_ok;
        logic [WW-1:0] rd;
        load_ctrl  = l_en;
        load_addr  = la;
        write_ctrl = w_en;
        write_addr = wa;
        write_data = wd;
        if (idle_exp) begin
            w_ok = w_en && (wa < DEPTH);
            if (w_en && !w_ok) err_exp = 1'b1;
            if (l_en) begin
                if (la < DEPTH) rd = (w_ok && wa == la) ? wd : mem_m[la[3:0]];
                else begin
                    rd      = '0;
                    err_exp = 1'b1;
                end
                for (int i = 0; i < NI; i++) sq[i].push_back('{cyc + i + 1, rd});
            end
            if (w_ok) mem_m[wa[3:0]] = wd;
        end else if (l_en || w_en) begin
            err_exp = 1'b1;
        end
        @(negedge clock);
        load_ctrl  = 1'b0;
        write_ctrl = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, '0, 1'b0, '0, '0);
    endtask

    task automatic do_reset(input int n);
        reset    = 1'b1;
        idle_exp = 1'b0;
        err_exp  = 1'b0;
        for (int i = 0; i < NI; i++) begin
            sq[i].delete();
            last_exp[i] = '0;
        end
        for (int k = 0; k < DEPTH; k++) mem_m[k] = '0;
        repeat (n) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic wait_ready();
        int k;
        for (k = 0; k < 200; k++) begin
            if (rdy[0] && rdy[1] && rdy[2]) break;
            @(negedge clock);
        end
        chk("ready_timeout", WW'(k < 200), WW'(1));
        idle_exp = 1'b1;
    endtask

    task automatic chk_err(input string tag);
        for (int i = 0; i < NI; i++) chk($sformatf("%s_rl%0d", tag, i + 1), WW'(er[i]), WW'(err_exp));
    endtask

    task automatic chk_drained();
        for (int i = 0; i < NI; i++) chk($sformatf("drained_rl%0d", i + 1), WW'(sq[i].size()), WW'(0));
    endtask

    initial begin
        for (int i = 0; i < NI; i++) last_exp[i] = '0;
        for (int k = 0; k < DEPTH; k++) mem_m[k] = '0;

        @(negedge clock);
        for (int i = 0; i < NI; i++) begin
            chk("rst_ready", WW'(rdy[i]), WW'(0));
            chk("rst_valid", WW'(lv[i]), WW'(0));
            chk("rst_data", ld[i], '0);
            chk("rst_err", WW'(er[i]), WW'(0));
        end

        // Clear takes exactly DEPTH cycles after release.
        do_reset(2);
        for (int c = 0; c < DEPTH; c++) begin
            for (int i = 0; i < NI; i++) chk($sformatf("clear_ready_c%0d", c), WW'(rdy[i]), WW'(0));
            @(negedge clock);
        end
        for (int i = 0; i < NI; i++) chk("ready_after_clear", WW'(rdy[i]), WW'(1));
        idle_exp = 1'b1;

        step(1'b1, 16'd0, 1'b0, '0, '0);
        idle(3);
        chk_err("err_after_first_load");

        step(1'b0, '0, 1'b1, 16'd3, rep(16'h3f1a));
        step(1'b1, 16'd3, 1'b0, '0, '0);
        idle(4);

        step(1'b1, 16'd5, 1'b1, 16'd5, rep(16'h4000));
        idle(4);

        step(1'b0, '0, 1'b1, 16'd0, rep(16'h3e4d));
        step(1'b0, '0, 1'b1, 16'd1, rep(16'h4000));
        step(1'b0, '0, 1'b1, 16'd2, rep(16'h3e4d));
        step(1'b1, 16'd0, 1'b0, '0, '0);
        step(1'b1, 16'd1, 1'b0, '0, '0);
        step(1'b1, 16'd2, 1'b0, '0, '0);
        idle(5);
        chk_drained();
        chk_err("err_before_oor");

        step(1'b0, '0, 1'b1, 16'd20, rep(16'hffff));
        chk_err("err_after_oor_write");
        step(1'b1, 16'd20, 1'b0, '0, '0);
        step(1'b1, 16'd4, 1'b0, '0, '0);
        step(1'b1, 16'h8004, 1'b0, '0, '0);
        idle(5);
        chk_err("err_sticky");

        // Reset one cycle after a load is in flight.
        step(1'b0, '0, 1'b1, 16'd7, rep(16'h1234));
        step(1'b1, 16'd7, 1'b0, '0, '0);
        do_reset(1);
        step(1'b1, 16'd9, 1'b0, '0, '0);
        chk_err("err_load_in_clear");
        wait_ready();
        chk_err("err_after_reclear");
        step(1'b1, 16'd7, 1'b0, '0, '0);
        step(1'b1, 16'd3, 1'b0, '0, '0);
        idle(5);
        chk_drained();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vector_mem_responder.md
Name: vector_mem_responder

Overview:
- Memory-side responder for the processing block's main-memory interface.
- Serves vector loads (load_ctrl/load_addr -> load_data) and accepts vector stores (write_ctrl/write_addr/write_data).
- Each memory word is one full register vector: LANES x LANE_W bits (32 x 16 = 512).
- Used in place of the behavioural memory in system benches; synthesisable as on-chip vector RAM with a reset-time clear sequencer.

Parameters:
- LANES, 32, 16-bit lanes per vector word.
- LANE_W, 16, bits per lane.
- ADDR_W, 16, address width of the load/write ports.
- DEPTH, 1024, number of words implemented; must satisfy DEPTH <= 2**ADDR_W.
- READ_LATENCY, 1, cycles from load request sample to load_valid; legal range 1..4.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- load_ctrl  in  1  load request, sampled each rising edge.
- load_addr  in  ADDR_W  load word address.
- load_data  out  LANES*LANE_W  returned vector word.
- load_valid  out  1  one-cycle strobe: load_data carries a response.
- write_ctrl  in  1  store request, sampled each rising edge.
- write_addr  in  ADDR_W  store word address.
- write_data  in  LANES*LANE_W  store vector word.
- ready  out  1  high when requests are accepted (state IDLE).
- err  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset values: ready=0, load_valid=0, load_data=0, err=0, all delay-line valid bits 0, state=CLEAR, clear_ptr=0.
- FSM states: CLEAR, IDLE.
- CLEAR:
  - Each cycle, write zero to mem[clear_ptr] and increment clear_ptr.
  - On the cycle that writes DEPTH-1, transition to IDLE; ready rises the following cycle.
  - A clear takes exactly DEPTH cycles after reset deasserts.
- Request handling while ready=0:
  - load_ctrl or write_ctrl high in CLEAR is dropped and sets err.
  - A dropped load produces no load_valid.
- IDLE loads:
  - A load sampled at edge N produces load_valid=1 for exactly one cycle, during the cycle following edge N+READ_LATENCY-1, with load_data = mem[load_addr].
  - Fully pipelined: one load per cycle, responses strictly in request order, no back-pressure.
  - load_data holds its last value while load_valid=0.
- IDLE writes:
  - A write sampled at edge N commits mem[write_addr] at that edge.
- Same-cycle load and write to the same address: write-first; the load returns the new write_data.
- A load issued after a write's commit edge returns the written data.
- Out-of-range accesses (addr >= DEPTH):
  - Load: still returns load_valid on schedule, with load_data=0; sets err.
  - Write: dropped; sets err.
  - Upper address bits are never aliased.
- Simultaneous error sources in one cycle set err once; no counting.
- Reset mid-operation:
  - In-flight loads are discarded; no load_valid is emitted for them.
  - FSM returns to CLEAR and memory is fully re-zeroed.
  - Contents present before reset are not retained.
- Widths:
  - No arithmetic on data; lanes pass bit-exact.
  - clear_ptr width is clog2(DEPTH); the compare against DEPTH-1 must not wrap.

Decomposition:
- Package vector_mem_pkg holds:
  - LANE_W and LANES defaults.
  - WORD_W = LANES*LANE_W.
  - State enum {CLEAR, IDLE}.
  - Memory opcode constants shared with the processing block: load 8'b00100000, store 8'b00010000.
- Sub-module mem_delay_line: READ_LATENCY-deep valid+data shift register with synchronous flush on reset. It produces load_valid/load_data from the array read stage.

Test Plan:
- Clear and first load (DEPTH=16, READ_LATENCY=1):
  - Stimulus: assert reset 2 cycles, release.
  - Response: ready=0 for exactly 16 cycles, then 1. A subsequent load of addr 0 returns load_valid=1 one cycle later with data all-zero, err=0.
- Write then read back:
  - Stimulus: write addr 3 with 0x3f1a in every lane; load addr 3 the next cycle.
  - Response: load_data = 0x3f1a repeated 32 times, load_valid high exactly one cycle.
- Same-cycle write/load (write-first):
  - Stimulus: write addr 5 = 0x4000 per lane and load addr 5 in the same cycle.
  - Response: load_data = 0x4000 per lane.
- Pipelined loads in order:
  - Setup: READ_LATENCY=2; preload addrs 0/1/2 with 0x3e4d/0x4000/0x3e4d per lane.
  - Stimulus: loads to addrs 0, 1, 2 on consecutive cycles.
  - Response: three consecutive load_valid cycles starting 2 cycles after the first request, data in order 0x3e4d, 0x4000, 0x3e4d.
- Out-of-range access (DEPTH=16):
  - Stimulus: write addr 20 = 0xffff per lane; then load addr 20; then load addr 4.
  - Response: load of 20 returns zero with load_valid and err=1; addr 4 contents unchanged (zero); err stays 1 until reset.
- Reset mid-burst and early requests:
  - Stimulus: issue a load in flight (READ_LATENCY=3) and assert reset on the next cycle; after release, issue a load during CLEAR.
  - Response: the reset-interrupted load emits no load_valid. Memory reads zero after ready returns. The load issued during CLEAR is dropped and sets err.
